// File: rtl/mc_control_fsm.sv
`timescale 1ns/1ps
// Multicycle MIPS-subset control FSM: memory wait states, mult/div handshake with
// timeout, and an exception path with a registered cause code.
module mc_control_fsm #(
    parameter int unsigned MEM_WAIT       = 0,
    parameter int unsigned MULDIV_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mult_done_in,
    input  logic       div_done_in,
    input  logic       div_zero_in,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCWriteCondNeg,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] RegDst,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUOp,
    output logic [2:0] WBDataSrc,
    output logic       HIWrite,
    output logic       LOWrite,
    output logic       MultStart,
    output logic       DivStart,
    output logic       EPCWrite,
    output logic [1:0] ExcCause,
    output logic [3:0] StateOut
);
    typedef enum logic [3:0] {
        S_RESET       = 4'd0,
        S_FETCH       = 4'd1,
        S_DECODE      = 4'd2,
        S_EXECUTE     = 4'd3,
        S_MEMORY      = 4'd4,
        S_WRITEBACK   = 4'd5,
        S_MULDIV_WAIT = 4'd6,
        S_EXCEPTION   = 4'd7
    } state_e;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                           F_OR = 6'b100101, F_SLT = 6'b101010, F_MULT = 6'b011000,
                           F_DIV = 6'b011010, F_MFHI = 6'b010000, F_MFLO = 6'b010010,
                           F_JR = 6'b001000;
    localparam logic [7:0] MEM_LAST = 8'(MEM_WAIT);
    localparam logic [7:0] MD_LAST  = 8'(MULDIV_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] cause_q, cause_d;
    logic       funct_legal;
    logic       md_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        funct_legal = 1'b0;
        case (funct)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT,
            F_MULT, F_DIV, F_MFHI, F_MFLO, F_JR: funct_legal = 1'b1;
            default: funct_legal = 1'b0;
        endcase
    end

    assign md_done = (funct == F_DIV) ? div_done_in : mult_done_in;

    always_comb begin
        PCWrite = 1'b0; PCWriteCond = 1'b0; PCWriteCondNeg = 1'b0; IorD = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0;
        ALUSrcA = 1'b0; RegDst = '0; ALUSrcB = '0; PCSource = '0; ALUOp = '0;
        WBDataSrc = '0; HIWrite = 1'b0; LOWrite = 1'b0; MultStart = 1'b0;
        DivStart = 1'b0; EPCWrite = 1'b0;
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1; ALUSrcB = 2'b01; ALUOp = 4'b0001;
                if (cnt_q == MEM_LAST) begin
                    IRWrite = 1'b1; PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11; ALUOp = 4'b0001;
                case (opcode)
                    OP_J: begin
                        PCWrite = 1'b1; PCSource = 2'b10; state_d = S_FETCH;
                    end
                    OP_JAL: begin
                        PCWrite = 1'b1; PCSource = 2'b10; RegWrite = 1'b1;
                        RegDst = 2'b11; WBDataSrc = 3'b111; state_d = S_FETCH;
                    end
                    OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE: state_d = S_EXECUTE;
                    OP_R: begin
                        state_d = funct_legal ? S_EXECUTE : S_EXCEPTION;
                        if (!funct_legal) cause_d = 2'b01;
                    end
                    default: begin
                        state_d = S_EXCEPTION; cause_d = 2'b01;
                    end
                endcase
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                state_d = S_FETCH;
                case (opcode)
                    OP_LW, OP_SW: begin
                        ALUSrcB = 2'b10; ALUOp = 4'b0001; state_d = S_MEMORY;
                    end
                    OP_ADDI: begin
                        ALUSrcB = 2'b10; ALUOp = 4'b0001; state_d = S_WRITEBACK;
                    end
                    OP_BEQ: begin
                        ALUOp = 4'b0010; PCWriteCond = 1'b1; PCSource = 2'b01;
                    end
                    OP_BNE: begin
                        ALUOp = 4'b0010; PCWriteCondNeg = 1'b1; PCSource = 2'b01;
                    end
                    OP_R: begin
                        case (funct)
                            F_ADD: begin ALUOp = 4'b0001; state_d = S_WRITEBACK; end
                            F_SUB, F_SLT: begin ALUOp = 4'b0010; state_d = S_WRITEBACK; end
                            F_AND: begin ALUOp = 4'b0011; state_d = S_WRITEBACK; end
                            F_OR:  begin ALUOp = 4'b0100; state_d = S_WRITEBACK; end
                            F_JR:  PCWrite = 1'b1;
                            F_MFHI, F_MFLO: state_d = S_WRITEBACK;
                            F_MULT: begin MultStart = 1'b1; state_d = S_MULDIV_WAIT; end
                            F_DIV: begin
                                if (div_zero_in) begin
                                    state_d = S_EXCEPTION; cause_d = 2'b11;
                                end else begin
                                    DivStart = 1'b1; state_d = S_MULDIV_WAIT;
                                end
                            end
                            default: state_d = S_FETCH;
                        endcase
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMORY: begin
                IorD = 1'b1;
                if (opcode == OP_SW) MemWrite = 1'b1;
                else                 MemRead  = 1'b1;
                if (cnt_q == MEM_LAST) state_d = (opcode == OP_SW) ? S_FETCH : S_WRITEBACK;
            end
            S_WRITEBACK: begin
                RegWrite = 1'b1;
                state_d = S_FETCH;
                if (opcode == OP_R) begin
                    RegDst = 2'b01;
                    case (funct)
                        F_SLT:   WBDataSrc = 3'b101;
                        F_MFHI:  WBDataSrc = 3'b010;
                        F_MFLO:  WBDataSrc = 3'b011;
                        default: WBDataSrc = 3'b000;
                    endcase
                end else begin
                    WBDataSrc = (opcode == OP_LW) ? 3'b001 : 3'b000;
                end
            end
            S_MULDIV_WAIT: begin
                // done is checked before expiry so a result on the last cycle still completes
                if (md_done) begin
                    HIWrite = 1'b1; LOWrite = 1'b1; state_d = S_FETCH;
                end else if (cnt_q == MD_LAST) begin
                    state_d = S_EXCEPTION; cause_d = 2'b10;
                end
            end
            S_EXCEPTION: begin
                EPCWrite = 1'b1; PCWrite = 1'b1; PCSource = 2'b11;
                state_d = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
        cnt_d = (state_d == state_q) ? cnt_q + 8'd1 : '0;
    end

    assign ExcCause = cause_q;
    assign StateOut = state_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
`timescale 1ns/1ps
// Bench for mc_control_fsm: two differently parameterised instances, one active at a
// time, checked cycle by cycle against an instruction-level model of the controller.
module tb_mc_control_fsm;
    localparam int unsigned WA = 0, TA = 4;
    localparam int unsigned WB = 2, TB = 6;

    typedef struct packed {
        logic       pcw, pcwc, pcwcn, iord, mr, mw, irw, rw, srca;
        logic [1:0] regdst, srcb, pcsrc;
        logic [3:0] aluop;
        logic [2:0] wbsrc;
        logic       hiw, low, ms, ds, epcw;
        logic [1:0] cause;
        logic [3:0] st;
    } ctrl_t;

    typedef struct {
        ctrl_t      exp;
        logic [5:0] op, fn;
        logic       md, dd, dz;
        string      tag;
    } cyc_t;

    typedef enum int {
        K_J, K_JAL, K_LW, K_SW, K_ADDI, K_BEQ, K_BNE, K_ADD, K_SUB, K_AND, K_OR,
        K_SLT, K_MULT, K_DIV, K_MFHI, K_MFLO, K_JR, K_BADOP, K_BADFN
    } kind_e;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       mult_done = 1'b0, div_done = 1'b0, div_zero = 1'b0;
    bit         sel = 1'b0;
    wire ctrl_t obs_a, obs_b;

    int unsigned ncomp = 0, nfail = 0;
    int unsigned mW = WA, mT = TA;
    logic [1:0]  m_cause = '0;
    cyc_t        cq[$];

    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_WAIT(WA), .MULDIV_TIMEOUT(TA)) dut_a (
        .clk(clk), .reset(rst_a), .opcode(opcode), .funct(funct),
        .mult_done_in(mult_done), .div_done_in(div_done), .div_zero_in(div_zero),
        .PCWrite(obs_a.pcw), .PCWriteCond(obs_a.pcwc), .PCWriteCondNeg(obs_a.pcwcn),
        .IorD(obs_a.iord), .MemRead(obs_a.mr), .MemWrite(obs_a.mw), .IRWrite(obs_a.irw),
        .RegWrite(obs_a.rw), .ALUSrcA(obs_a.srca), .RegDst(obs_a.regdst),
        .ALUSrcB(obs_a.srcb), .PCSource(obs_a.pcsrc), .ALUOp(obs_a.aluop),
        .WBDataSrc(obs_a.wbsrc), .HIWrite(obs_a.hiw), .LOWrite(obs_a.low),
        .MultStart(obs_a.ms), .DivStart(obs_a.ds), .EPCWrite(obs_a.epcw),
        .ExcCause(obs_a.cause), .StateOut(obs_a.st)
    );

    mc_control_fsm #(.MEM_WAIT(WB), .MULDIV_TIMEOUT(TB)) dut_b (
        .clk(clk), .reset(rst_b), .opcode(opcode), .funct(funct),
        .mult_done_in(mult_done), .div_done_in(div_done), .div_zero_in(div_zero),
        .PCWrite(obs_b.pcw), .PCWriteCond(obs_b.pcwc), .PCWriteCondNeg(obs_b.pcwcn),
        .IorD(obs_b.iord), .MemRead(obs_b.mr), .MemWrite(obs_b.mw), .IRWrite(obs_b.irw),
        .RegWrite(obs_b.rw), .ALUSrcA(obs_b.srca), .RegDst(obs_b.regdst),
        .ALUSrcB(obs_b.srcb), .PCSource(obs_b.pcsrc), .ALUOp(obs_b.aluop),
        .WBDataSrc(obs_b.wbsrc), .HIWrite(obs_b.hiw), .LOWrite(obs_b.low),
        .MultStart(obs_b.ms), .DivStart(obs_b.ds), .EPCWrite(obs_b.epcw),
        .ExcCause(obs_b.cause), .StateOut(obs_b.st)
    );

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic ctrl_t blank(input logic [3:0] st);
        ctrl_t c;
        c = '0;
        c.st = st;
        c.cause = m_cause;
        return c;
    endfunction

    function automatic bit legal_fn(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h18, 6'h1a, 6'h10, 6'h12, 6'h08};
    endfunction

    task automatic check(input string tag, input ctrl_t exp);
        ctrl_t o;
        o = sel ? obs_b : obs_a;
        ncomp++;
        assert (o === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, o, exp);
        end
    endtask

    task automatic push(input ctrl_t c, input logic [5:0] op, input logic [5:0] fn,
                        input logic md, input logic dd, input logic dz, input string tag);
        cyc_t y;
        y.exp = c; y.op = op; y.fn = fn; y.md = md; y.dd = dd; y.dz = dz; y.tag = tag;
        cq.push_back(y);
    endtask

    task automatic exc_cycle(input logic [1:0] cause, input logic [5:0] op,
                             input logic [5:0] fn, input string nm);
        ctrl_t c;
        m_cause = cause;
        c = blank(4'd7);
        c.epcw = 1'b1; c.pcw = 1'b1; c.pcsrc = 2'b11;
        push(c, op, fn, rb(), rb(), rb(), {nm, " exc"});
    endtask

    // Expected per-cycle controls for one instruction; n = wait cycles until done.
    task automatic build(input kind_e k, input logic [5:0] op, input logic [5:0] fn,
                         input int unsigned n, input logic zero);
        ctrl_t c;
        logic  dzv, dn;
        string nm;
        nm = k.name();
        for (int unsigned i = 0; i <= mW; i++) begin
            c = blank(4'd1);
            c.mr = 1'b1; c.srcb = 2'b01; c.aluop = 4'd1;
            if (i == mW) begin c.irw = 1'b1; c.pcw = 1'b1; end
            push(c, 6'($urandom), 6'($urandom), rb(), rb(), rb(), $sformatf("%s fetch%0d", nm, i));
        end
        c = blank(4'd2);
        c.srcb = 2'b11; c.aluop = 4'd1;
        if (k == K_J || k == K_JAL) begin
            c.pcw = 1'b1; c.pcsrc = 2'b10;
            if (k == K_JAL) begin c.rw = 1'b1; c.regdst = 2'b11; c.wbsrc = 3'b111; end
            push(c, op, fn, rb(), rb(), rb(), {nm, " decode"});
            return;
        end
        push(c, op, fn, rb(), rb(), rb(), {nm, " decode"});
        if (k == K_BADOP || k == K_BADFN) begin
            exc_cycle(2'b01, op, fn, nm);
            return;
        end
        c = blank(4'd3);
        c.srca = 1'b1;
        dzv = rb();
        case (k)
            K_LW, K_SW, K_ADDI: begin c.srcb = 2'b10; c.aluop = 4'd1; end
            K_BEQ:  begin c.aluop = 4'd2; c.pcwc = 1'b1; c.pcsrc = 2'b01; end
            K_BNE:  begin c.aluop = 4'd2; c.pcwcn = 1'b1; c.pcsrc = 2'b01; end
            K_ADD:  c.aluop = 4'd1;
            K_SUB, K_SLT: c.aluop = 4'd2;
            K_AND:  c.aluop = 4'd3;
            K_OR:   c.aluop = 4'd4;
            K_JR:   c.pcw = 1'b1;
            K_MULT: c.ms = 1'b1;
            K_DIV:  begin c.ds = !zero; dzv = zero; end
            default: ;
        endcase
        push(c, op, fn, rb(), rb(), dzv, {nm, " execute"});
        if (k inside {K_BEQ, K_BNE, K_JR}) return;
        if (k == K_DIV && zero) begin
            exc_cycle(2'b11, op, fn, nm);
            return;
        end
        if (k == K_MULT || k == K_DIV) begin
            for (int unsigned w = 1; w <= mT; w++) begin
                c = blank(4'd6);
                dn = (w >= n);
                if (dn) begin c.hiw = 1'b1; c.low = 1'b1; end
                if (k == K_MULT) push(c, op, fn, dn, rb(), rb(), $sformatf("%s wait%0d", nm, w));
                else             push(c, op, fn, rb(), dn, rb(), $sformatf("%s wait%0d", nm, w));
                if (dn) return;
            end
            exc_cycle(2'b10, op, fn, nm);
            return;
        end
        if (k == K_LW || k == K_SW) begin
            for (int unsigned i = 0; i <= mW; i++) begin
                c = blank(4'd4);
                c.iord = 1'b1;
                if (k == K_SW) c.mw = 1'b1; else c.mr = 1'b1;
                push(c, op, fn, rb(), rb(), rb(), $sformatf("%s mem%0d", nm, i));
            end
            if (k == K_SW) return;
        end
        c = blank(4'd5);
        c.rw = 1'b1;
        case (k)
            K_LW:   c.wbsrc = 3'b001;
            K_ADDI: c.wbsrc = 3'b000;
            K_SLT:  begin c.regdst = 2'b01; c.wbsrc = 3'b101; end
            K_MFHI: begin c.regdst = 2'b01; c.wbsrc = 3'b010; end
            K_MFLO: begin c.regdst = 2'b01; c.wbsrc = 3'b011; end
            default: c.regdst = 2'b01;
        endcase
        push(c, op, fn, rb(), rb(), rb(), {nm, " writeback"});
    endtask

    task automatic encode(input kind_e k, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        op = 6'h00;
        case (k)
            K_J:    op = 6'h02;
            K_JAL:  op = 6'h03;
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2b;
            K_ADDI: op = 6'h08;
            K_BEQ:  op = 6'h04;
            K_BNE:  op = 6'h05;
            K_ADD:  fn = 6'h20;
            K_SUB:  fn = 6'h22;
            K_AND:  fn = 6'h24;
            K_OR:   fn = 6'h25;
            K_SLT:  fn = 6'h2a;
            K_MULT: fn = 6'h18;
            K_DIV:  fn = 6'h1a;
            K_MFHI: fn = 6'h10;
            K_MFLO: fn = 6'h12;
            K_JR:   fn = 6'h08;
            K_BADOP: begin
                op = 6'h3f;
                for (int i = 0; i < 20; i++) begin
                    op = 6'($urandom);
                    if (!(op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2b})) break;
                    op = 6'h3f;
                end
            end
            K_BADFN: begin
                for (int i = 0; i < 20 && legal_fn(fn); i++) fn = 6'($urandom);
                if (legal_fn(fn)) fn = 6'h3f;
            end
            default: ;
        endcase
    endtask

    task automatic run_q(input int unsigned max_cycles);
        cyc_t y;
        for (int unsigned i = 0; i < max_cycles && cq.size() > 0; i++) begin
            y = cq.pop_front();
            @(negedge clk);
            opcode = y.op; funct = y.fn;
            mult_done = y.md; div_done = y.dd; div_zero = y.dz;
            #1 check(y.tag, y.exp);
        end
    endtask

    task automatic exec_raw(input kind_e k, input logic [5:0] op, input logic [5:0] fn,
                            input int unsigned n, input logic zero);
        build(k, op, fn, n, zero);
        run_q(1000);
    endtask

    task automatic exec(input kind_e k, input int unsigned n, input logic zero);
        logic [5:0] op, fn;
        encode(k, op, fn);
        exec_raw(k, op, fn, n, zero);
    endtask

    task automatic reset_dut(input bit which);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        sel = which;
        mW = which ? WB : WA;
        mT = which ? TB : TA;
        m_cause = '0;
        cq.delete();
        @(negedge clk);
        #1 check("reset held", blank(4'd0));
        if (which) rst_b = 1'b0; else rst_a = 1'b0;
        #1 check("reset released", blank(4'd0));
    endtask

    task automatic random_burst(input int unsigned count);
        kind_e k;
        for (int unsigned i = 0; i < count; i++) begin
            k = kind_e'($urandom_range(0, 18));
            exec(k, $urandom_range(1, mT + 2), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        // Instance A: no memory wait states, four-cycle mult/div timeout
        reset_dut(1'b0);
        exec(K_ADD, 1, 1'b0);
        exec(K_LW, 1, 1'b0);
        exec(K_DIV, 1000, 1'b0);
        exec(K_DIV, 1, 1'b1);
        exec_raw(K_BADOP, 6'h3f, 6'h00, 1, 1'b0);
        exec(K_MULT, TA, 1'b0);
        exec(K_SW, 1, 1'b0);
        exec(K_BNE, 1, 1'b0);
        exec(K_JAL, 1, 1'b0);
        exec(K_JR, 1, 1'b0);
        exec(K_BADFN, 1, 1'b0);
        random_burst(60);

        // Reset asserted in the middle of a mult wait
        exec(K_BADOP, 1, 1'b0);
        build(K_MULT, 6'h00, 6'h18, 1000, 1'b0);
        run_q(mW + 5);
        #1 rst_a = 1'b1;
        m_cause = '0;
        cq.delete();
        #1 check("reset mid muldiv", blank(4'd0));
        reset_dut(1'b0);
        exec(K_ADDI, 1, 1'b0);

        // Instance B: two memory wait states, six-cycle timeout
        reset_dut(1'b1);
        exec(K_LW, 1, 1'b0);
        exec(K_MULT, 5, 1'b0);
        exec(K_DIV, TB, 1'b0);
        exec(K_DIV, 1000, 1'b0);
        exec(K_SW, 1, 1'b0);
        exec(K_J, 1, 1'b0);
        random_burst(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
